nibble_add_seq: RTL and testbench

- Multi-word adder/subtractor that reuses one 4-bit adder slice for every nibble.
- Sequences operands of NIBBLES x 4 bits through the slice one nibble per clock, LSB first.
- Chains carry between nibbles and reports sum, carry and signed overflow through a start/busy/done handshake.
- Serves as the area-lean wide arithmetic path beside the existing 4-bit combinational adder.

---
 rtl/nibble_add_seq.sv | 106 ++++++++++
 tb/tb_nibble_add_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_add_seq : wide add/subtract through one 4-bit slice, LSB nibble first
// Revision 1.0
// ----------------------------------------------------------------------------
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   sub_i,
  input  logic [4*NIBBLES-1:0]   op_a_i,
  input  logic [4*NIBBLES-1:0]   op_b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES-1:0]   result_o,
  output logic                   cy_o,
  output logic                   ovf_o
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [W-1:0]      a_q, b_q, work_q;
  logic              sub_q, carry_q;
  logic [IDXW-1:0]   idx_q;

  logic [3:0]        a_nib, b_nib;
  logic [4:0]        sum5;
  logic              c3;
  logic [W-1:0]      work_d;

  always_comb begin
    a_nib  = a_q[int'(idx_q)*4 +: 4];
    b_nib  = b_q[int'(idx_q)*4 +: 4] ^ {4{sub_q}};
    sum5   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the bit-3 sum and its two inputs.
    c3     = a_nib[3] ^ b_nib[3] ^ sum5[3];
    work_d = work_q;
    work_d[int'(idx_q)*4 +: 4] = sum5[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      cy_o     <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            sub_q   <= sub_i;
            carry_q <= sub_i;
            idx_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          work_q  <= work_d;
          carry_q <= sum5[4];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == C_LAST_IDX) begin
            // Outputs land on the same edge that enters DONE.
            result_o <= work_d;
            cy_o     <= sum5[4];
            ovf_o    <= c3 ^ sum5[4];
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`default_nettype none
// Self-checking bench for nibble_add_seq with NIBBLES=4 against an arithmetic model.
module tb_nibble_add_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          sub_i = 1'b0;
  logic [W-1:0]  op_a_i = '0;
  logic [W-1:0]  op_b_i = '0;
  logic          busy_o, done_o, cy_o, ovf_o;
  logic [W-1:0]  result_o;

  int errors = 0;
  int checks = 0;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .sub_i    (sub_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cy_o     (cy_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  // Reference: {cy, ovf, result} from plain integer arithmetic and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int unsigned ua, ub, full;
    logic [W-1:0] r;
    logic c, v;
    ua   = int'(a);
    ub   = int'(b);
    full = s ? (ua + (32'h10000 - ub)) : (ua + ub);
    r    = full[W-1:0];
    c    = (full >= 32'h10000);
    if (s) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {c, v, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start_i = 1'b1;
    op_a_i  = a;
    op_b_i  = b;
    sub_i   = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy_o, done_o, cy_o, ovf_o, result_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b cy=%b ovf=%b res=%h, expected all 0",
               busy_o, done_o, cy_o, ovf_o, result_o);
    end
  endtask

  // Runs one operation from cycle 0 through the cycle after done; checks timing and result.
  task automatic test_directed;
    logic [W-1:0] va [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007, 16'h8000, 16'h0000};
    logic [W-1:0] vb [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h8000, 16'h0007, 16'h0005, 16'h0001, 16'h0000};
    logic         vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W+1:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = model(va[i], vb[i], vs[i]);
      drive_start(va[i], vb[i], vs[i]);
      tick();
      start_i = 1'b0;
      op_a_i  = W'($urandom);
      op_b_i  = W'($urandom);
      for (int c = 1; c <= N; c++) begin
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL dir%0d_busy_c%0d: got busy=%b done=%b, expected busy=1 done=0", i, c, busy_o, done_o);
        end
        tick();
      end
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || {cy_o, ovf_o, result_o} !== exp) begin
        errors++;
        $display("FAIL dir%0d_done: got done=%b busy=%b cy=%b ovf=%b res=%h, expected done=1 busy=0 cy=%b ovf=%b res=%h",
                 i, done_o, busy_o, cy_o, ovf_o, result_o, exp[W+1], exp[W], exp[W-1:0]);
      end
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || {cy_o, ovf_o, result_o} !== exp) begin
        errors++;
        $display("FAIL dir%0d_hold: got done=%b busy=%b cy=%b ovf=%b res=%h, expected done=0 busy=0 res=%h held",
                 i, done_o, busy_o, cy_o, ovf_o, result_o, exp[W-1:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic         s;
    logic [W+1:0] exp;
    int           wait_cnt;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 5 == 0) a = {a[W-1], {(W-1){~a[W-1]}}};
      s = 1'($urandom);
      exp = model(a, b, s);
      drive_start(a, b, s);
      tick();
      start_i  = 1'b0;
      wait_cnt = 1;
      while (done_o !== 1'b1 && wait_cnt < 20) begin
        tick();
        wait_cnt++;
      end
      checks++;
      if (wait_cnt != N + 1 || {cy_o, ovf_o, result_o} !== exp) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h sub=%b: got cycle=%0d cy=%b ovf=%b res=%h, expected cycle=%0d cy=%b ovf=%b res=%h",
                 i, a, b, s, wait_cnt, cy_o, ovf_o, result_o, N + 1, exp[W+1], exp[W], exp[W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy;
    logic [W+1:0] exp;
    exp = model(16'h1234, 16'h4321, 1'b0);
    drive_start(16'h1234, 16'h4321, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    drive_start(16'hABCD, 16'h1111, 1'b1);
    tick();
    start_i = 1'b0;
    tick();
    tick();
    checks++;
    if (done_o !== 1'b1 || {cy_o, ovf_o, result_o} !== exp) begin
      errors++;
      $display("FAIL busy_start_result: got done=%b res=%h cy=%b ovf=%b, expected done=1 res=%h cy=%b ovf=%b",
               done_o, result_o, cy_o, ovf_o, exp[W-1:0], exp[W+1], exp[W]);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got busy=%b done=%b, expected busy=0 done=0", busy_o, done_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] exp1, exp2;
    exp1 = model(16'h1234, 16'h4321, 1'b0);
    exp2 = model(16'h0005, 16'h0007, 1'b1);
    drive_start(16'h1234, 16'h4321, 1'b0);
    tick();
    start_i = 1'b0;
    for (int c = 1; c < N; c++) tick();
    tick();
    drive_start(16'h0005, 16'h0007, 1'b1);
    checks++;
    if (done_o !== 1'b1 || {cy_o, ovf_o, result_o} !== exp1) begin
      errors++;
      $display("FAIL b2b_first: got done=%b res=%h, expected done=1 res=%h", done_o, result_o, exp1[W-1:0]);
    end
    tick();
    start_i = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || {cy_o, ovf_o, result_o} !== exp1) begin
        errors++;
        $display("FAIL b2b_run_c%0d: got busy=%b done=%b res=%h, expected busy=1 done=0 res=%h",
                 c, busy_o, done_o, result_o, exp1[W-1:0]);
      end
      tick();
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || {cy_o, ovf_o, result_o} !== exp2) begin
      errors++;
      $display("FAIL b2b_second: got done=%b cy=%b ovf=%b res=%h, expected done=1 cy=%b ovf=%b res=%h",
               done_o, cy_o, ovf_o, result_o, exp2[W+1], exp2[W], exp2[W-1:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    logic [W+1:0] exp;
    logic         saw_done;
    exp = model(16'h1234, 16'h4321, 1'b0);
    drive_start(16'h1234, 16'h4321, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || cy_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b res=%h cy=%b ovf=%b, expected all 0",
               busy_o, done_o, result_o, cy_o, ovf_o);
    end
    saw_done = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: got activity=1, expected 0");
    end
    drive_start(16'h1234, 16'h4321, 1'b0);
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= N; c++) tick();
    checks++;
    if (done_o !== 1'b1 || {cy_o, ovf_o, result_o} !== exp) begin
      errors++;
      $display("FAIL midrun_recover: got done=%b res=%h, expected done=1 res=%h", done_o, result_o, exp[W-1:0]);
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (busy_o === 1'b1 && done_o === 1'b1) begin
      errors++;
      $display("FAIL busy_done_overlap: got both 1, expected never together");
    end
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
